// File: rtl/lbm_divider.sv
// Signed fixed-point divider for the LBM velocity path: Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
// quotient from a sequential restoring divider, with saturation and divide-by-zero handling.
`timescale 1ns/1ps
module lbm_divider #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 16
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         div_start,
   input  logic signed [DATA_WIDTH-1:0] dividend,
   input  logic signed [DATA_WIDTH-1:0] divisor,
   output logic signed [DATA_WIDTH-1:0] quotient,
   output logic                         div_valid,
   output logic                         div_busy,
   output logic                         div_by_zero
);

   localparam int ITER  = DATA_WIDTH + FRAC_BITS;
   localparam int CNT_W = $clog2(ITER) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(ITER - 1);
   localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [ITER-1:0]       POS_LIM  = {{FRAC_BITS{1'b0}}, MAX_POS};
   localparam logic [ITER-1:0]       NEG_LIM  = {{FRAC_BITS{1'b0}}, MIN_NEG};

   // Unsigned magnitude; the most negative value maps to 2^(DATA_WIDTH-1) without overflow.
   function automatic logic [DATA_WIDTH-1:0] f_abs(input logic signed [DATA_WIDTH-1:0] x);
      f_abs = x[DATA_WIDTH-1] ? (~x + ONE) : x;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] f_saturate(input logic [ITER-1:0] mag,
                                                        input logic           neg);
      if (!neg)
         f_saturate = (mag > POS_LIM) ? MAX_POS : mag[DATA_WIDTH-1:0];
      else
         f_saturate = (mag > NEG_LIM) ? MIN_NEG : (~mag[DATA_WIDTH-1:0] + ONE);
   endfunction

   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_rem;
   logic [ITER-1:0]       r_q;
   logic [DATA_WIDTH-1:0] r_dmag;
   logic                  r_neg;
   logic [DATA_WIDTH-1:0] r_quotient;
   logic                  r_dbz;

   logic [DATA_WIDTH:0]   w_rem_shift;
   logic [DATA_WIDTH:0]   w_diff;
   logic                  w_ge;
   logic [DATA_WIDTH-1:0] w_rem_next;
   logic [ITER-1:0]       w_q_next;
   logic                  w_mag_nz;
   logic [DATA_WIDTH-1:0] w_result;

   // r_q starts as the shifted dividend and fills with quotient bits from the LSB end.
   // A borrow out of the DATA_WIDTH+1-bit subtraction means the divisor did not fit.
   always_comb begin
      w_rem_shift = {r_rem, r_q[ITER-1]};
      w_diff      = w_rem_shift - {1'b0, r_dmag};
      w_ge        = ~w_diff[DATA_WIDTH];
      w_rem_next  = w_ge ? w_diff[DATA_WIDTH-1:0] : w_rem_shift[DATA_WIDTH-1:0];
      w_q_next    = {r_q[ITER-2:0], w_ge};
      w_mag_nz    = |w_q_next;
      w_result    = f_saturate(w_q_next, r_neg & w_mag_nz);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_q        <= '0;
         r_dmag     <= '0;
         r_neg      <= 1'b0;
         r_quotient <= '0;
         r_dbz      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (div_start) begin
                  r_cnt  <= '0;
                  r_rem  <= '0;
                  r_q    <= {f_abs(dividend), {FRAC_BITS{1'b0}}};
                  r_dmag <= f_abs(divisor);
                  r_neg  <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                  if (divisor == '0) begin
                     r_state    <= S_DONE;
                     r_quotient <= dividend[DATA_WIDTH-1] ? MIN_NEG : MAX_POS;
                     r_dbz      <= 1'b1;
                  end else begin
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_rem_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state    <= S_DONE;
                  r_quotient <= w_result;
                  r_dbz      <= 1'b0;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign quotient    = r_quotient;
   assign div_valid   = (r_state == S_DONE);
   assign div_busy    = (r_state != S_IDLE);
   assign div_by_zero = r_dbz;

endmodule
